vga_sync: RTL

- VGA timing generator: the producer end of the pixel interface.
- Drives pixel coordinates, active-video flag and pixel clock to pixel-rendering blocks, e.g. the byte-as-LEDs renderer and later overlays.
- Drives hsync/vsync to the monitor connector.
- Default timing is 640x480@60 Hz, with a 25 MHz pixel rate derived from a 50 MHz system clock.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_px_div.sv | 42 ++++
 rtl/vga_sync.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, derived totals and renderer colour codes
package vga_pkg;

    // 640x480@60 Hz timing, in pixels and lines
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Counters are 10 bits wide, so a total above this cannot be represented
    localparam int VGA_MAX_TOTAL = 1024;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    // 3-bit RGB colour codes shared with the pixel renderers
    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

endpackage

// File: rtl/vga_px_div.sv
// rtl/vga_px_div.sv - system-clock divider producing a registered pixel clock and a pixel-step strobe
module vga_px_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    output logic px_clk,
    output logic px_tick
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    generate
        if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
            $error("vga_px_div: CLK_DIV must be an even integer >= 2");
        end
    endgenerate

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;

    // Free-running phase counter 0..CLK_DIV-1
    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
    end

    // px_clk is derived from the next phase so it lines up with div_cnt and falls on the tick-ending edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            px_clk  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            px_clk  <= (div_nxt >= DIV_HALF);
        end
    end

    assign px_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA timing generator (optional frame counter via VGA_SYNC_FRAME_CNT_EN)
module vga_sync
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        px_clk,
    output logic        px_tick,
    output logic [9:0]  x_px,
    output logic [9:0]  y_px,
    output logic        activevideo,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > VGA_MAX_TOTAL || V_TOTAL > VGA_MAX_TOTAL) begin : g_bad_total
            $error("vga_sync: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    vga_px_div #(
        .CLK_DIV (CLK_DIV)
    ) u_px_div (
        .clk     (clk),
        .rstn    (rstn),
        .px_clk  (px_clk),
        .px_tick (px_tick)
    );

    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       at_origin;
    logic       av_nxt;
    logic       hs_on;
    logic       vs_on;

    // Next raster position and the decoded flags for it, so every output updates on one edge with no skew
    always_comb begin
        h_nxt = x_px + 10'd1;
        v_nxt = y_px;
        if (x_px == H_LAST) begin
            h_nxt = '0;
            v_nxt = (y_px == V_LAST) ? '0 : y_px + 10'd1;
        end
        at_origin = (h_nxt == '0) && (v_nxt == '0);
        av_nxt    = ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
        hs_on     = ({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END);
        vs_on     = ({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END);
    end

    // Raster counters and registered outputs; reset parks at the last pixel so the first tick lands on (0,0)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_px        <= H_LAST;
            y_px        <= V_LAST;
            activevideo <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else if (px_tick) begin
            x_px        <= h_nxt;
            y_px        <= v_nxt;
            activevideo <= av_nxt;
            hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
            frame_start <= at_origin;
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic first_frame;

    // Frame index: the frame entered straight out of reset is frame 0, each later frame start advances it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first_frame <= 1'b1;
            frame_cnt   <= '0;
        end else if (px_tick && at_origin) begin
            first_frame <= 1'b0;
            if (!first_frame) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
